// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM states, default
// fault instruction and the fetch/load address check.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;
  localparam int unsigned LAT_CNT_W        = 4;

  // Operands are zero-extended to 64 bits so base+size cannot wrap.
  function automatic logic addr_good(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] size);
    return (addr[1:0] == 2'b00) && (addr >= base) && (addr < base + size);
  endfunction

endpackage

// File: rtl/imem_responder_array.sv
// Word RAM for the instruction image: one synchronous read port and one write port.
// A read and a write to the same index on the same edge return the old word.
module imem_responder_array #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned WORDS        = 1024,
  parameter int unsigned IDX_W        = 10
) (
  input  logic                    clk,
  input  logic                    rd_en,
  input  logic [IDX_W-1:0]        rd_index,
  output logic [ADDRESS_SIZE-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_index,
  input  logic [ADDRESS_SIZE-1:0] wr_data
);

  logic [ADDRESS_SIZE-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_index];
    end
    if (wr_en) begin
      mem[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: one outstanding request, fixed latency, faults on
// misaligned/out-of-range addresses, image loaded through a side write port.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned             ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS = 32'h1000,
  parameter logic [ADDRESS_SIZE-1:0] MEM_SIZE     = 32'h1000,
  parameter int unsigned             LATENCY      = 2,
  parameter logic [ADDRESS_SIZE-1:0] NOP_WORD     = NOP_WORD_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDRESS_SIZE-1:0] req_address,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ADDRESS_SIZE-1:0] rsp_instruction,
  output logic [ADDRESS_SIZE-1:0] rsp_address,
  output logic                    rsp_fault,
  input  logic                    load_en,
  input  logic [ADDRESS_SIZE-1:0] load_address,
  input  logic [ADDRESS_SIZE-1:0] load_data
);

  localparam int unsigned WORDS     = 32'(MEM_SIZE >> 2);
  localparam int unsigned IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned WAIT_LAST = (LATENCY > 1) ? LATENCY - 2 : 0;

  state_t                  state, state_n;
  logic [LAT_CNT_W-1:0]    cnt;
  logic                    have_data;
  logic                    accept;
  logic                    req_good;
  logic                    rd_en;
  logic [IDX_W-1:0]        req_idx, held_idx, rd_index;
  logic [IDX_W-1:0]        wr_index;
  logic                    wr_en;
  logic [ADDRESS_SIZE-1:0] rd_data;

  assign req_good = addr_good(64'(req_address), 64'(BOOT_ADDRESS), 64'(MEM_SIZE));
  assign req_idx  = IDX_W'((req_address - BOOT_ADDRESS) >> 2);
  assign held_idx = IDX_W'((rsp_address - BOOT_ADDRESS) >> 2);
  assign rd_index = (state == IDLE) ? req_idx : held_idx;

  assign wr_en    = load_en && addr_good(64'(load_address), 64'(BOOT_ADDRESS), 64'(MEM_SIZE));
  assign wr_index = IDX_W'((load_address - BOOT_ADDRESS) >> 2);

  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // The accept cycle counts as the first latency cycle, so WAIT lasts LATENCY-1
  // cycles; with LATENCY==1 a good fetch reads the array on the accept edge.
  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!req_good) begin
            state_n = RESP;
          end else if (LATENCY == 1) begin
            state_n = RESP;
            rd_en   = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == LAT_CNT_W'(WAIT_LAST)) begin
          state_n = RESP;
          rd_en   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rsp_address <= '0;
      rsp_fault   <= 1'b0;
      have_data   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        rsp_address <= req_address;
        rsp_fault   <= !req_good;
        cnt         <= '0;
        have_data   <= 1'b0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (rd_en) begin
        have_data <= 1'b1;
      end
    end
  end

  always_comb begin
    rsp_instruction = '0;
    if (rsp_fault) begin
      rsp_instruction = NOP_WORD;
    end else if (have_data) begin
      rsp_instruction = rd_data;
    end
  end

  imem_responder_array #(
    .ADDRESS_SIZE(ADDRESS_SIZE),
    .WORDS       (WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_index(rd_index),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_index(wr_index),
    .wr_data (load_data)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with LATENCY=2, BOOT_ADDRESS=0x1000, MEM_SIZE=0x1000.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instruction;
  logic [31:0] rsp_address;
  logic        rsp_fault;
  logic        load_en;
  logic [31:0] load_address;
  logic [31:0] load_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_responder #(
    .ADDRESS_SIZE(32),
    .BOOT_ADDRESS(32'h1000),
    .MEM_SIZE    (32'h1000),
    .LATENCY     (2),
    .NOP_WORD    (32'h13)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_address    (req_address),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_instruction(rsp_instruction),
    .rsp_address    (rsp_address),
    .rsp_fault      (rsp_fault),
    .load_en        (load_en),
    .load_address   (load_address),
    .load_data      (load_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en      = 1'b1;
    load_address = a;
    load_data    = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] a,
                           input logic [31:0] d, input logic f);
    chk1({tag, ".rsp_valid"}, rsp_valid, 1'b1);
    chk ({tag, ".instr"}, rsp_instruction, d);
    chk ({tag, ".addr"}, rsp_address, a);
    chk1({tag, ".fault"}, rsp_fault, f);
    chk1({tag, ".req_ready_low"}, req_ready, 1'b0);
  endtask

  task automatic fetch_good(input string tag, input logic [31:0] a, input logic [31:0] d);
    rsp_ready   = 1'b1;
    req_valid   = 1'b1;
    req_address = a;
    chk1({tag, ".c0_ready"}, req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk1({tag, ".c1_valid"}, rsp_valid, 1'b0);
    chk1({tag, ".c1_ready"}, req_ready, 1'b0);
    tick();
    check_rsp(tag, a, d, 1'b0);
    tick();
    chk1({tag, ".c3_valid"}, rsp_valid, 1'b0);
    chk1({tag, ".c3_ready"}, req_ready, 1'b1);
  endtask

  task automatic fetch_bad(input string tag, input logic [31:0] a);
    rsp_ready   = 1'b1;
    req_valid   = 1'b1;
    req_address = a;
    tick();
    req_valid = 1'b0;
    check_rsp(tag, a, 32'h13, 1'b1);
    tick();
    chk1({tag, ".c2_ready"}, req_ready, 1'b1);
    chk1({tag, ".c2_valid"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    b2b_addr[0] = 32'h1000; b2b_data[0] = 32'hDEADBEEF;
    b2b_addr[1] = 32'h1004; b2b_data[1] = 32'h22222222;
    b2b_addr[2] = 32'h1008; b2b_data[2] = 32'hCAFEF00D;

    reset = 1'b1; req_valid = 1'b0; req_address = '0; rsp_ready = 1'b0;
    load_en = 1'b0; load_address = '0; load_data = '0;
    tick();
    chk1("rst.req_ready", req_ready, 1'b1);
    chk1("rst.rsp_valid", rsp_valid, 1'b0);
    chk ("rst.instr", rsp_instruction, 32'h0);
    chk ("rst.addr", rsp_address, 32'h0);
    chk1("rst.fault", rsp_fault, 1'b0);

    // Loads are accepted while reset is held; bad-address loads must be dropped.
    load(32'h1000, 32'hDEADBEEF);
    load(32'h1004, 32'h11111111);
    load(32'h1008, 32'hCAFEF00D);
    load(32'h1FFC, 32'h0BADC0DE);
    load(32'h0FFC, 32'hFFFFFFFF);
    load(32'h1001, 32'h55555555);
    load(32'h2000, 32'h77777777);
    reset = 1'b0;
    tick();

    fetch_good("t1", 32'h1000, 32'hDEADBEEF);

    fetch_bad("t2_mis", 32'h1002);
    fetch_bad("t2_low", 32'h0FFC);
    fetch_bad("t2_high", 32'h2000);
    fetch_good("t2_last", 32'h1FFC, 32'h0BADC0DE);

    // Backpressure: second request stays pending on req_valid until IDLE.
    rsp_ready   = 1'b0;
    req_valid   = 1'b1;
    req_address = 32'h1004;
    tick();
    req_address = 32'h1008;
    chk1("t3.wait_ready", req_ready, 1'b0);
    tick();
    for (int unsigned i = 0; i < 5; i++) begin
      check_rsp("t3.hold", 32'h1004, 32'h11111111, 1'b0);
      tick();
    end
    check_rsp("t3.hold", 32'h1004, 32'h11111111, 1'b0);
    rsp_ready = 1'b1;
    tick();
    chk1("t3.idle_ready", req_ready, 1'b1);
    chk1("t3.idle_valid", rsp_valid, 1'b0);
    tick();
    req_valid = 1'b0;
    chk1("t3.second_wait", rsp_valid, 1'b0);
    tick();
    check_rsp("t3.second", 32'h1008, 32'hCAFEF00D, 1'b0);
    tick();

    // Load on the WAIT->RESP edge: the response carries the old word.
    req_valid   = 1'b1;
    req_address = 32'h1004;
    tick();
    req_valid = 1'b0;
    load_en = 1'b1; load_address = 32'h1004; load_data = 32'h22222222;
    tick();
    load_en = 1'b0;
    check_rsp("t4.old", 32'h1004, 32'h11111111, 1'b0);
    tick();
    fetch_good("t4.new", 32'h1004, 32'h22222222);

    // Asynchronous reset in WAIT.
    req_valid   = 1'b1;
    req_address = 32'h1008;
    tick();
    req_valid = 1'b0;
    chk1("t5.in_wait", req_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk1("t5.async_ready", req_ready, 1'b1);
    chk1("t5.async_valid", rsp_valid, 1'b0);
    tick();
    reset = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk1("t5.no_stale", rsp_valid, 1'b0);
    end
    fetch_good("t5.kept", 32'h1008, 32'hCAFEF00D);

    // Back-to-back fetches with req_valid held: one response every 3 cycles.
    rsp_ready   = 1'b1;
    req_valid   = 1'b1;
    req_address = b2b_addr[0];
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      if (i == 2) req_valid = 1'b0;
      else req_address = b2b_addr[i+1];
      chk1("t6.wait", rsp_valid, 1'b0);
      tick();
      check_rsp("t6.rsp", b2b_addr[i], b2b_data[i], 1'b0);
      tick();
      chk1("t6.idle", req_ready, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
